// File: rtl/note_pkg.sv
// Shared widths, rest code and slot state encoding for the track scheduler.
// Imported by track_slot and track_scheduler.
package note_pkg;
   localparam int unsigned NOTE_W    = 6;
   localparam int unsigned DUR_W     = 4;
   localparam int unsigned NUM_SLOTS = 4;
   localparam int unsigned NOTE_REST = 0;

   typedef enum logic {
      SlotFree,
      SlotActive
   } slot_state_e;
endpackage

// File: rtl/track_slot.sv
// One note slot: holds the note code and its remaining beat count.
// A FREE slot always shows note 0.
module track_slot #(
   parameter int unsigned NOTE_W = note_pkg::NOTE_W,
   parameter int unsigned DUR_W  = note_pkg::DUR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [NOTE_W-1:0] note,
   input  logic [DUR_W-1:0]  dur,
   input  logic              tick,
   input  logic              clr,
   output logic [NOTE_W-1:0] track,
   output logic              busy
);
   import note_pkg::*;

   slot_state_e       state_q, state_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [DUR_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      note_d  = note_q;
      cnt_d   = cnt_q;
      if (clr) begin
         state_d = SlotFree;
         note_d  = '0;
         cnt_d   = '0;
      end else if (load) begin
         // Loading wins over the tick, so a retriggered slot skips this beat's decrement.
         state_d = SlotActive;
         note_d  = note;
         cnt_d   = (dur == '0) ? DUR_W'(1) : dur;
      end else if (tick && state_q == SlotActive && cnt_q != '0) begin
         if (cnt_q == DUR_W'(1)) begin
            state_d = SlotFree;
            note_d  = '0;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - DUR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SlotFree;
         note_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         note_q  <= note_d;
         cnt_q   <= cnt_d;
      end
   end

   assign track = note_q;
   assign busy  = (state_q == SlotActive);
endmodule

// File: rtl/track_scheduler.sv
// Four-slot note scheduler: retriggers matching notes, otherwise allocates the
// lowest free slot; beat ticks count durations down until slots free up.
module track_scheduler #(
   parameter int unsigned NOTE_W = note_pkg::NOTE_W,
   parameter int unsigned DUR_W  = note_pkg::DUR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat_tick,
   input  logic              pause,
   input  logic              flush,
   input  logic              note_valid,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [DUR_W-1:0]  dur_in,
   output logic              note_ready,
   output logic [NOTE_W-1:0] track0,
   output logic [NOTE_W-1:0] track1,
   output logic [NOTE_W-1:0] track2,
   output logic [NOTE_W-1:0] track3,
   output logic [3:0]        busy
);
   import note_pkg::*;

   logic [NOTE_W-1:0] track_w [NUM_SLOTS];
   logic [3:0]        busy_w;
   logic [3:0]        match;
   logic [3:0]        load;
   logic              note_is_rest;
   logic              xfer;
   logic              tick;

   assign note_is_rest = (note_in == NOTE_W'(NOTE_REST));
   assign tick         = beat_tick & ~pause;

   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         match[i] = busy_w[i] && (track_w[i] == note_in) && !note_is_rest;
      end
   end

   assign note_ready = !rst && !flush && ((~busy_w != '0) || (match != '0));
   assign xfer       = note_valid && note_ready;

   // Retrigger takes precedence; otherwise pick the lowest-index free slot.
   always_comb begin
      load = '0;
      if (xfer && !note_is_rest) begin
         if (match != '0) begin
            load = match;
         end else begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
               if (!busy_w[i]) load = 4'(1 << i);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      track_slot #(
         .NOTE_W (NOTE_W),
         .DUR_W  (DUR_W)
      ) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load[g]),
         .note  (note_in),
         .dur   (dur_in),
         .tick  (tick),
         .clr   (flush),
         .track (track_w[g]),
         .busy  (busy_w[g])
      );
   end

   assign track0 = track_w[0];
   assign track1 = track_w[1];
   assign track2 = track_w[2];
   assign track3 = track_w[3];
   assign busy   = busy_w;
endmodule

// File: tb/tb_track_scheduler.sv
// Scoreboard bench for track_scheduler: a slot-level reference model predicts
// note_ready and the post-edge slot contents; a monitor checks them at negedge.
module tb_track_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       beat_tick = 1'b0;
   logic       pause = 1'b0;
   logic       flush = 1'b0;
   logic       note_valid = 1'b0;
   logic [5:0] note_in = '0;
   logic [3:0] dur_in = '0;
   logic       note_ready;
   logic [5:0] track0, track1, track2, track3;
   logic [3:0] busy;

   track_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .beat_tick  (beat_tick),
      .pause      (pause),
      .flush      (flush),
      .note_valid (note_valid),
      .note_in    (note_in),
      .dur_in     (dur_in),
      .note_ready (note_ready),
      .track0     (track0),
      .track1     (track1),
      .track2     (track2),
      .track3     (track3),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic            ready;
      logic [3:0][5:0] trk;
      logic [3:0]      bsy;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   // Reference model: note and remaining beats per slot (0 beats = free).
   int m_note[4] = '{0, 0, 0, 0};
   int m_rem[4]  = '{0, 0, 0, 0};

   task automatic step(input bit r, input bit v, input int n, input int d,
                       input bit t, input bit p, input bit f);
      exp_t e;
      bit   anyfree = 0;
      bit   anymatch = 0;
      int   tgt = -1;
      @(posedge clk);
      #1;
      rst = r; note_valid = v; note_in = 6'(n); dur_in = 4'(d);
      beat_tick = t; pause = p; flush = f;
      for (int i = 0; i < 4; i++) begin
         if (m_rem[i] == 0) anyfree = 1;
         else if (n != 0 && m_note[i] == n) anymatch = 1;
      end
      e.ready = !r && !f && (anyfree || anymatch);
      if (r || f) begin
         for (int i = 0; i < 4; i++) begin m_note[i] = 0; m_rem[i] = 0; end
      end else begin
         if (v && e.ready && n != 0) begin
            for (int i = 0; i < 4; i++) if (m_rem[i] > 0 && m_note[i] == n) tgt = i;
            if (tgt < 0) for (int i = 3; i >= 0; i--) if (m_rem[i] == 0) tgt = i;
         end
         for (int i = 0; i < 4; i++) begin
            if (i == tgt) begin
               m_note[i] = n;
               m_rem[i]  = (d == 0) ? 1 : d;
            end else if (t && !p && m_rem[i] > 0) begin
               m_rem[i]--;
               if (m_rem[i] == 0) m_note[i] = 0;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         e.trk[i] = 6'(m_note[i]);
         e.bsy[i] = (m_rem[i] > 0);
      end
      exp_q.push_back(e);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: ready checked in the issuing cycle, slot state one edge later.
   initial begin
      exp_t cur;
      exp_t pend;
      bit   have = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (have) begin
            total++;
            if ({track3, track2, track1, track0} !== pend.trk || busy !== pend.bsy) begin
               bad++;
               $display("FAIL state cyc=%0d got trk=%h busy=%b exp trk=%h busy=%b", cyc,
                        {track3, track2, track1, track0}, busy, pend.trk, pend.bsy);
            end
         end
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            total++;
            if (note_ready !== cur.ready) begin
               bad++;
               $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, note_ready, cur.ready);
            end
            pend = cur;
            have = 1;
         end else begin
            have = 0;
         end
      end
   end

   initial begin
      // Reset, then fill all four slots; note 33 must not be accepted.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 5, 2, 1, 0, 1);
      step(0, 1, 5, 2, 0, 0, 0);
      step(0, 1, 9, 2, 0, 0, 0);
      step(0, 1, 12, 2, 0, 0, 0);
      step(0, 1, 20, 2, 0, 0, 0);
      step(0, 1, 33, 2, 0, 0, 0);
      // Two ticks free everything.
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 1, 33, 0, 0, 0, 0);
      // Retrigger in a tick cycle.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 7, 1, 0, 0, 0);
      step(0, 1, 7, 3, 1, 0, 0);
      idle(1);
      // Pause holds across ticks, then two ticks free the slot.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 2, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      // Flush drops a simultaneous transfer; rst mid-note clears all.
      step(0, 1, 9, 5, 0, 0, 0);
      step(0, 1, 11, 4, 0, 0, 1);
      step(0, 1, 9, 5, 0, 0, 0);
      step(1, 1, 13, 5, 1, 0, 0);
      idle(1);
      // dur 0 lasts exactly one tick; rest transfer changes nothing.
      step(0, 1, 4, 0, 0, 0, 0);
      step(0, 1, 0, 3, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      idle(1);
      // Randomised traffic over a small note alphabet to force matches and full slots.
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15)
                                                              : $urandom_range(0, 3),
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0);
      end
      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/track_scheduler.md
TRACK_SCHEDULER -- requirements
Module: track_scheduler

Interface
REQ-001 Parameter NOTE_W, default 6, note code width (0 = rest/empty).
REQ-002 Parameter DUR_W, default 4, duration field width in beat ticks.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 beat_tick  input  1  one-cycle pulse per beat.
REQ-006 pause  input  1  high freezes all duration counters.
REQ-007 flush  input  1  one-cycle pulse, empties all slots.
REQ-008 note_valid  input  1  note request present.
REQ-009 note_in  input  NOTE_W  requested note code.
REQ-010 dur_in  input  DUR_W  requested duration in beats.
REQ-011 note_ready  output  1  scheduler can accept a note this cycle.
REQ-012 track0, track1, track2, track3  output  NOTE_W each  current note per slot, for the light decoder.
REQ-013 busy  output  4  bit i high when slot i is ACTIVE.

Function
REQ-014 Each of the 4 slots shall be FREE (track = 0, counter = 0) or ACTIVE (track = note, counter = remaining beats).
REQ-015 A transfer shall occur on a rising clk edge where note_valid and note_ready are both high.
REQ-016 note_in = 0 on a transfer shall be accepted and discarded, with no slot change.
REQ-017 note_ready shall be high when any slot is FREE in registered state, or when note_in matches an ACTIVE slot's note; it is combinational from registered state and note_in.
REQ-018 A transfer whose note_in matches an ACTIVE slot shall retrigger that slot: counter reloads, no new slot is allocated.
REQ-019 Otherwise a transfer shall allocate the lowest-index FREE slot, load note_in, and set the counter to dur_in, or to 1 if dur_in = 0; the slot becomes ACTIVE the next cycle.
REQ-020 On beat_tick with pause low, every ACTIVE slot not being loaded or retriggered in that cycle shall decrement its counter by 1.
REQ-021 A slot whose counter decrements from 1 to 0 shall become FREE (track = 0) in the same update.
REQ-022 A slot loaded or retriggered in a beat_tick cycle shall take the new duration and skip that decrement.
REQ-023 A slot freed by beat_tick shall not be reused in the same cycle; allocation uses pre-update state.
REQ-024 pause high shall block decrements only; transfers and flush still act.
REQ-025 flush shall set all slots FREE the next cycle and override any simultaneous transfer, which is dropped; note_ready shall be low in a flush cycle.
REQ-026 track0..3 and busy shall be registered outputs, with latency 1 cycle from the causing edge.
REQ-027 Counters shall never wrap: no decrement below 0, and a loaded duration is at most 2^DUR_W-1.

Reset
REQ-028 While rst is high, all slots shall be FREE: track0..3 = 0, busy = 0, counters = 0.
REQ-029 While rst is high, note_ready shall be low and no transfer shall be accepted.
REQ-030 rst asserted mid-duration shall discard all notes, with no residual lights after release.
REQ-031 rst shall take priority over flush, beat_tick and transfers.

Structure
REQ-032 NOTE_W, DUR_W, NOTE_REST (= 0) and the slot state encoding shall live in shared package note_pkg.
REQ-033 Sub-module track_slot shall hold one slot's note, counter and FREE/ACTIVE state.
REQ-034 track_slot shall have inputs load, dur, tick and clr; it is instantiated 4 times.
REQ-035 The top level shall contain the allocation priority encoder, match logic and ready generation.

Verification
REQ-036 Reset, then send notes 5, 9, 12, 20 with dur 2 each on consecutive cycles -> track0..3 = 5, 9, 12, 20; busy = 4'b1111; note_ready low for note 33.
REQ-037 All slots full, then 2 beat_ticks -> all tracks 0 after the 2nd tick's edge; note_ready high again.
REQ-038 Slot0 holds note 7 (dur 1), then note_valid with note 7, dur 3 in the same cycle as beat_tick -> slot0 stays 7 with counter 3, busy[0] stays 1.
REQ-039 pause high across 5 beat_ticks with note 3, dur 2 active -> unchanged; 2 ticks after pause low -> track0 = 0.
REQ-040 flush in the same cycle as a valid note 11 -> all tracks 0, note 11 not stored; rst mid-note -> all outputs 0 the next cycle.
REQ-041 dur_in = 0 with note 4 -> freed after exactly 1 beat_tick; note_in = 0 transfer -> busy unchanged.
